// File: rtl/bus_mem_responder.sv
// bus_mem_responder
//   A single-port word memory that answers two independent request channels.
//   The instruction channel is a fetch-only port with an active-low
//   request/ready handshake. The data channel handles loads and stores
//   through a shared tri-state data bus.
//
// Ports
//   clk       : single clock; all state changes on the rising edge
//   rst       : synchronous, active-high reset
//   iaddr     : fetch byte address
//   iack_n    : fetch request (active-low)
//   idata     : fetched word; holds its last value between responses
//   iready_n  : fetch response strobe (active-low, one cycle)
//   daddr     : data byte address
//   dreq      : data request (active-high)
//   dwrite    : 1 = store, 0 = load (sampled with dreq)
//   dsize     : 00 byte, 01 halfword, 10/11 word
//   ddata     : store data in; load data out during the load response only
//   dready_n  : data response strobe (active-low, one cycle)
//   dbusy     : data channel occupied; new requests are ignored while high
module bus_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int I_LAT     = 1,
    parameter int D_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iaddr,
    input  logic        iack_n,
    output logic [31:0] idata,
    output logic        iready_n,
    input  logic [31:0] daddr,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [1:0]  dsize,
    inout  wire  [31:0] ddata,
    output logic        dready_n,
    output logic        dbusy
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic {I_IDLE, I_WAIT} istate_t;
    typedef enum logic [1:0] {D_IDLE, D_WAIT, D_RESP} dstate_t;

    logic [31:0] mem [MEM_WORDS];

    // High address bits alias onto the array; byte offsets are irrelevant
    // for fetches and are taken from the captured copy for stores.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2]};

    // ---------------- instruction channel ----------------
    istate_t        istate, istate_nxt;
    logic [3:0]     icnt;
    logic [AW-1:0]  iidx;
    logic [31:0]    idata_q;
    logic           ifire;
    logic           iresp;

    always_comb begin
        istate_nxt = istate;
        ifire      = 1'b0;
        iresp      = 1'b0;
        case (istate)
            I_IDLE: begin
                if (!iack_n) begin
                    ifire      = 1'b1;
                    istate_nxt = I_WAIT;
                end
            end
            I_WAIT: begin
                if (icnt == 4'd0) begin
                    iresp      = 1'b1;
                    istate_nxt = I_IDLE;
                end
            end
            default: istate_nxt = I_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            istate  <= I_IDLE;
            icnt    <= 4'd0;
            idata_q <= 32'd0;
        end else begin
            istate <= istate_nxt;
            if (ifire) begin
                iidx <= iaddr[AW+1:2];
                icnt <= 4'(I_LAT - 1);
            end else if (istate == I_WAIT && icnt != 4'd0) begin
                icnt <= icnt - 4'd1;
            end
            if (iresp)
                idata_q <= mem[iidx];
        end
    end

    // The response cycle reads the array combinationally, so a store that
    // commits on the same edge is not yet visible to this fetch.
    assign idata    = iresp ? mem[iidx] : idata_q;
    assign iready_n = ~iresp;

    // ---------------- data channel ----------------
    dstate_t        dstate, dstate_nxt;
    logic [3:0]     dcnt;
    logic [AW-1:0]  didx;
    logic [1:0]     dlane;
    logic           dwr;
    logic [1:0]     dsz;
    logic [31:0]    dwdata;
    logic           dfire;
    logic [3:0]     be;
    logic [31:0]    wword;
    logic           ddata_oe;

    always_comb begin
        dstate_nxt = dstate;
        dfire      = 1'b0;
        case (dstate)
            D_IDLE: begin
                if (dreq) begin
                    dfire      = 1'b1;
                    dstate_nxt = D_WAIT;
                end
            end
            D_WAIT:  if (dcnt == 4'd0) dstate_nxt = D_RESP;
            D_RESP:  dstate_nxt = D_IDLE;
            default: dstate_nxt = D_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dstate <= D_IDLE;
            dcnt   <= 4'd0;
            dwr    <= 1'b0;
        end else begin
            dstate <= dstate_nxt;
            if (dfire) begin
                didx   <= daddr[AW+1:2];
                dlane  <= daddr[1:0];
                dwr    <= dwrite;
                dsz    <= dsize;
                dwdata <= ddata;
                dcnt   <= 4'(D_LAT - 1);
            end else if (dstate == D_WAIT && dcnt != 4'd0) begin
                dcnt <= dcnt - 4'd1;
            end
        end
    end

    // Replicate the low data bytes across lanes so the byte enables alone
    // decide which lanes change.
    always_comb begin
        be    = 4'hF;
        wword = dwdata;
        case (dsz)
            2'b00: begin
                be    = 4'b0001 << dlane;
                wword = {4{dwdata[7:0]}};
            end
            2'b01: begin
                be    = dlane[1] ? 4'b1100 : 4'b0011;
                wword = {2{dwdata[15:0]}};
            end
            default: begin
                be    = 4'hF;
                wword = dwdata;
            end
        endcase
    end

    // Commit on the edge closing the response cycle; a reset on that edge
    // discards the store.
    always_ff @(posedge clk) begin
        if (!rst && dstate == D_RESP && dwr) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k])
                    mem[didx][8*k +: 8] <= wword[8*k +: 8];
            end
        end
    end

    assign ddata_oe = (dstate == D_RESP) && !dwr;
    assign ddata    = ddata_oe ? mem[didx] : 32'bz;
    assign dbusy    = (dstate != D_IDLE);
    assign dready_n = (dstate != D_RESP);

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: reset state, fetch timing, store
// lane merging, load-after-store, busy-ignore, reset abort, address wrap and
// fetch/store ordering on the same word.
module tb_bus_mem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int I_LAT     = 1;
    localparam int D_LAT     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr;
    logic        iack_n;
    logic [31:0] idata;
    logic        iready_n;
    logic [31:0] daddr;
    logic        dreq;
    logic        dwrite;
    logic [1:0]  dsize;
    wire  [31:0] ddata;
    logic        dready_n;
    logic        dbusy;

    logic        tb_drive;
    logic [31:0] tb_ddata;
    assign ddata = tb_drive ? tb_ddata : 32'bz;

    int checks = 0;
    int errors = 0;

    bus_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .I_LAT    (I_LAT),
        .D_LAT    (D_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .iaddr   (iaddr),
        .iack_n  (iack_n),
        .idata   (idata),
        .iready_n(iready_n),
        .daddr   (daddr),
        .dreq    (dreq),
        .dwrite  (dwrite),
        .dsize   (dsize),
        .ddata   (ddata),
        .dready_n(dready_n),
        .dbusy   (dbusy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dbusy"}, {31'd0, dbusy}, 32'd0);
        chk({tag, "_dready_n"}, {31'd0, dready_n}, 32'd1);
        chk({tag, "_oe"}, {31'd0, dut.ddata_oe}, 32'd0);
    endtask

    // Present a data request for one cycle; returns in the first wait cycle.
    task automatic dstart(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata);
        dreq     = 1'b1;
        dwrite   = wr;
        daddr    = addr;
        dsize    = size;
        tb_drive = wr;
        tb_ddata = wdata;
        cyc();
        dreq     = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic dxact(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input logic [31:0] exp_rd);
        dstart(wr, addr, size, wdata);
        for (int i = 0; i < D_LAT; i++) begin
            chk({tag, "_wait_dbusy"}, {31'd0, dbusy}, 32'd1);
            chk({tag, "_wait_dready_n"}, {31'd0, dready_n}, 32'd1);
            chk({tag, "_wait_oe"}, {31'd0, dut.ddata_oe}, 32'd0);
            cyc();
        end
        chk({tag, "_resp_dready_n"}, {31'd0, dready_n}, 32'd0);
        chk({tag, "_resp_dbusy"}, {31'd0, dbusy}, 32'd1);
        chk({tag, "_resp_oe"}, {31'd0, dut.ddata_oe}, {31'd0, ~wr});
        if (!wr)
            chk({tag, "_rdata"}, ddata, exp_rd);
        cyc();
        chk_idle({tag, "_after"});
    endtask

    task automatic ifetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        iack_n = 1'b0;
        iaddr  = addr;
        cyc();
        iack_n = 1'b1;
        for (int i = 0; i < I_LAT - 1; i++) begin
            chk({tag, "_wait_iready_n"}, {31'd0, iready_n}, 32'd1);
            cyc();
        end
        chk({tag, "_iready_n"}, {31'd0, iready_n}, 32'd0);
        chk({tag, "_idata"}, idata, exp);
        cyc();
        chk({tag, "_pulse_end"}, {31'd0, iready_n}, 32'd1);
        chk({tag, "_hold"}, idata, exp);
    endtask

    initial begin
        // Reset with both requests asserted: nothing may be accepted.
        rst      = 1'b1;
        iack_n   = 1'b0;
        iaddr    = 32'h10;
        dreq     = 1'b1;
        dwrite   = 1'b0;
        daddr    = 32'h0;
        dsize    = 2'b10;
        tb_drive = 1'b0;
        tb_ddata = 32'h0;
        cyc();
        cyc();
        cyc();
        chk("rst_iready_n", {31'd0, iready_n}, 32'd1);
        chk("rst_idata", idata, 32'd0);
        chk_idle("rst");
        iack_n = 1'b1;
        dreq   = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_iready_n", {31'd0, iready_n}, 32'd1);
        chk_idle("post_rst");

        // Fetch of a word written through the data port.
        dxact("st_mem4", 1'b1, 32'h10, 2'b10, 32'h0050_0093, 32'h0);
        ifetch("fetch_mem4", 32'h10, 32'h0050_0093);

        // Word store then immediate load.
        dxact("st_beef", 1'b1, 32'h20, 2'b10, 32'hDEAD_BEEF, 32'h0);
        dxact("ld_beef", 1'b0, 32'h20, 2'b10, 32'h0, 32'hDEAD_BEEF);

        // Byte/halfword lane merging; upper store-data bytes must be ignored.
        dxact("st_base", 1'b1, 32'h20, 2'b10, 32'h1122_3344, 32'h0);
        dxact("st_b3",   1'b1, 32'h23, 2'b00, 32'h1234_56AA, 32'h0);
        dxact("st_h0",   1'b1, 32'h20, 2'b01, 32'h9ABC_5566, 32'h0);
        dxact("ld_merge1", 1'b0, 32'h20, 2'b10, 32'h0, 32'hAA22_5566);
        dxact("st_h2",   1'b1, 32'h22, 2'b01, 32'hFFFF_7788, 32'h0);
        dxact("st_b1",   1'b1, 32'h21, 2'b00, 32'hFFFF_FFCC, 32'h0);
        dxact("ld_merge2", 1'b0, 32'h20, 2'b10, 32'h0, 32'h7788_CC66);
        dxact("st_sz3",  1'b1, 32'h25, 2'b11, 32'h0BAD_F00D, 32'h0);
        dxact("ld_sz3",  1'b0, 32'h24, 2'b10, 32'h0, 32'h0BAD_F00D);
        dxact("ld_unal", 1'b0, 32'h26, 2'b00, 32'h0, 32'h0BAD_F00D);

        // Requests while busy are ignored, including a would-be store.
        dstart(1'b0, 32'h10, 2'b10, 32'h0);
        dreq   = 1'b1;
        dwrite = 1'b1;
        daddr  = 32'h20;
        for (int i = 0; i < D_LAT; i++) begin
            chk("busy_ign_wait", {31'd0, dready_n}, 32'd1);
            cyc();
        end
        chk("busy_ign_resp", {31'd0, dready_n}, 32'd0);
        chk("busy_ign_rdata", ddata, 32'h0050_0093);
        dreq = 1'b0;
        cyc();
        chk_idle("busy_ign_after1");
        cyc();
        chk_idle("busy_ign_after2");
        dxact("ld_after_ign", 1'b0, 32'h20, 2'b10, 32'h0, 32'h7788_CC66);

        // Reset during the wait of a store aborts it.
        dxact("st_zero40", 1'b1, 32'h40, 2'b10, 32'h0, 32'h0);
        dstart(1'b1, 32'h40, 2'b10, 32'hCAFE_BABE);
        chk("abort_busy", {31'd0, dbusy}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle("abort_after");
        chk("abort_idata", idata, 32'd0);
        cyc();
        chk_idle("abort_after2");
        dxact("ld_abort1", 1'b0, 32'h40, 2'b10, 32'h0, 32'h0);

        // Reset during the response cycle of a store also discards it.
        dstart(1'b1, 32'h40, 2'b10, 32'h1234_5678);
        for (int i = 0; i < D_LAT; i++) cyc();
        chk("abort2_resp", {31'd0, dready_n}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle("abort2_after");
        dxact("ld_abort2", 1'b0, 32'h40, 2'b10, 32'h0, 32'h0);

        // Address wrap above the array.
        dxact("st_mem2", 1'b1, 32'h08, 2'b10, 32'h2222_AAAA, 32'h0);
        dxact("ld_wrap", 1'b0, 32'(4 * MEM_WORDS + 8), 2'b10, 32'h0, 32'h2222_AAAA);
        dxact("st_wrap", 1'b1, 32'(4 * MEM_WORDS + 12), 2'b10, 32'h3333_4444, 32'h0);
        dxact("ld_mem3", 1'b0, 32'h0C, 2'b10, 32'h0, 32'h3333_4444);

        // Fetch responding in the commit cycle sees the old word.
        dstart(1'b1, 32'h10, 2'b10, 32'h5A5A_5A5A);
        for (int i = 0; i < D_LAT - 1; i++) cyc();
        iack_n = 1'b0;
        iaddr  = 32'h10;
        cyc();
        iack_n = 1'b1;
        chk("same_cyc_dready_n", {31'd0, dready_n}, 32'd0);
        chk("same_cyc_iready_n", {31'd0, iready_n}, 32'd0);
        chk("same_cyc_old", idata, 32'h0050_0093);
        cyc();
        chk("same_cyc_hold", idata, 32'h0050_0093);
        ifetch("fetch_new", 32'h10, 32'h5A5A_5A5A);

        // Fetch captured on the commit edge sees the new word.
        dstart(1'b1, 32'h10, 2'b10, 32'h6B6B_6B6B);
        for (int i = 0; i < D_LAT; i++) cyc();
        chk("cap_commit_resp", {31'd0, dready_n}, 32'd0);
        iack_n = 1'b0;
        iaddr  = 32'h10;
        cyc();
        iack_n = 1'b1;
        chk("cap_commit_iready_n", {31'd0, iready_n}, 32'd0);
        chk("cap_commit_new", idata, 32'h6B6B_6B6B);
        cyc();
        chk("cap_commit_end", {31'd0, iready_n}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, 1024, number of 32-bit words in the internal array (power of two).
REQ-002 Parameter I_LAT, 1, cycles from fetch acceptance to instruction response (1..15).
REQ-003 Parameter D_LAT, 2, cycles from data acceptance to data response (1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 iaddr  input  32  instruction fetch byte address.
REQ-007 iack_n  input  1  fetch request, active-low.
REQ-008 idata  output  32  fetched instruction word.
REQ-009 iready_n  output  1  instruction valid, active-low, one-cycle pulse.
REQ-010 daddr  input  32  data byte address.
REQ-011 dreq  input  1  data request, active-high.
REQ-012 dwrite  input  1  1 = store, 0 = load; sampled with dreq.
REQ-013 dsize  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-014 ddata  inout  32  store data from core; driven by this block only during a load response.
REQ-015 dready_n  output  1  data response, active-low, one-cycle pulse.
REQ-016 dbusy  output  1  data side occupied; new dreq ignored while high.

Function
REQ-017 Word index = address[log2(MEM_WORDS)+1:2]; higher bits alias (wrap); address[1:0] ignored for loads.
REQ-018 Instruction FSM states: I_IDLE, I_WAIT; independent of data FSM.
REQ-019 I_IDLE with iack_n=0: capture iaddr, load counter with I_LAT-1, go I_WAIT.
REQ-020 I_WAIT: counter nonzero -> decrement; counter zero -> idata = mem[captured index], iready_n=0 for exactly that cycle, return to I_IDLE.
REQ-021 iack_n=0 in the response cycle is not accepted; next fetch accepted at earliest the following cycle; fetch throughput = one per I_LAT+1 cycles.
REQ-022 idata holds its last value between responses.
REQ-023 Data FSM states: D_IDLE, D_WAIT, D_RESP.
REQ-024 D_IDLE with dreq=1: capture daddr, dwrite, dsize, ddata (store data); counter = D_LAT-1; go D_WAIT; dbusy=1 from next cycle.
REQ-025 D_WAIT: dbusy=1; counter nonzero -> decrement; counter zero -> go D_RESP.
REQ-026 D_RESP: dbusy=1, dready_n=0 for exactly one cycle; next state D_IDLE (dbusy=0).
REQ-027 Load in D_RESP: ddata driven with full aligned word mem[index]; sign/zero extension and lane selection belong to the core.
REQ-028 Store commits in the D_RESP cycle using byte enables: byte -> lane address[1:0], data byte 0; halfword -> lanes {address[1],0} and +1, data bytes 1:0; word -> all lanes, address[1:0] ignored.
REQ-029 Little-endian: lane k = bits 8k+7:8k.
REQ-030 ddata is high-impedance in every cycle except a load D_RESP cycle; never driven during stores.
REQ-031 dreq in D_WAIT/D_RESP is ignored, not queued; core must hold dreq until dready_n seen, then re-present.
REQ-032 Same-word instruction fetch and store in the same cycle: fetch captured after the store commits returns new data; fetch responding in the commit cycle returns old data.
REQ-033 Load immediately following a store to the same word returns the stored value.

Reset
REQ-034 rst=1 on a rising edge: both FSMs -> idle, counters 0, iready_n=1, dready_n=1, dbusy=0, idata=0, ddata released; in-flight requests discarded, pending store not committed.
REQ-035 Memory array contents are not cleared by reset.
REQ-036 Requests presented while rst=1 are not accepted.

Verification
REQ-037 I_LAT=1, mem[4]=0x00500093, iaddr=0x10, iack_n=0 one cycle -> next cycle iready_n=0, idata=0x00500093, one cycle only.
REQ-038 D_LAT=2, store word 0xDEADBEEF to 0x20, then load 0x20 -> store: dbusy high 2 cycles then dready_n pulse; load returns ddata=0xDEADBEEF in its dready_n cycle.
REQ-039 mem[8]=0x11223344, store byte 0xAA to 0x23, halfword 0x5566 to 0x20 -> load 0x20 returns 0xAA225566.
REQ-040 Second dreq asserted while dbusy=1 -> no extra dready_n pulse; only after re-presentation in D_IDLE.
REQ-041 rst pulsed during D_WAIT of a store to 0x40 (previous value 0x0) -> dbusy=0, dready_n=1 next cycle, mem at 0x40 still 0x0.
REQ-042 Address 4*MEM_WORDS+0x8 load -> returns mem[2] (wrap); ddata tri-stated outside load responses throughout all scenarios.
